// File: rtl/booth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_pkg                                                    |
// | Description : Shared types, Booth digit codes and iteration-count helper   |
// |               for the sequential Booth multiplier.                         |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit code is {neg, one, two}
    localparam logic [2:0] ZERO = 3'b000;
    localparam logic [2:0] POS1 = 3'b010;
    localparam logic [2:0] NEG1 = 3'b110;
    localparam logic [2:0] POS2 = 3'b001;
    localparam logic [2:0] NEG2 = 3'b101;

    function automatic int n_iter(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_recoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_recoder                                                |
// | Description : Combinational Booth window decoder; 2-bit window gives       |
// |               radix-2 digits, 3-bit window gives radix-4 digits.           |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module booth_recoder
    import booth_pkg::*;
#(
    parameter int WIN_W = 2
)(
    input  logic [WIN_W-1:0] window,
    output logic             neg,
    output logic             one,
    output logic             two
);

    logic [2:0] w_digit;

    generate
        if (WIN_W == 3) begin : g_radix4
            always_comb begin
                w_digit = ZERO;
                case (window)
                    3'b001, 3'b010: w_digit = POS1;
                    3'b011:         w_digit = POS2;
                    3'b100:         w_digit = NEG2;
                    3'b101, 3'b110: w_digit = NEG1;
                    default:        w_digit = ZERO;
                endcase
            end
        end else begin : g_radix2
            always_comb begin
                w_digit = ZERO;
                case (window)
                    2'b01:   w_digit = POS1;
                    2'b10:   w_digit = NEG1;
                    default: w_digit = ZERO;
                endcase
            end
        end
    endgenerate

    assign {neg, one, two} = w_digit;

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_mult_seq                                               |
// | Description : Sequential signed/unsigned Booth multiplier with valid/ready |
// |               handshakes. Define BOOTH_RADIX4_EN for radix-4 recoding.     |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 3)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               tc,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_RADIX4_EN
    localparam bit c_RADIX4 = 1'b1;
`else
    localparam bit c_RADIX4 = 1'b0;
`endif
    localparam int c_EXT_W = WIDTH + 2;
    localparam int c_ACC_W = c_EXT_W + 1;
    localparam int c_WIN_W = c_RADIX4 ? 3 : 2;
    localparam logic [CNT_W-1:0] c_N_ITER = CNT_W'(n_iter(WIDTH, c_RADIX4));

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_EXT_W-1:0]   r_q;
    logic                 r_qm1;
    logic [c_EXT_W-1:0]   r_mcand;
    logic [CNT_W-1:0]     r_cnt;

    logic [c_WIN_W-1:0]   w_window;
    logic                 w_neg;
    logic                 w_one;
    logic                 w_two;
    logic [c_ACC_W-1:0]   w_mag;
    logic [c_ACC_W-1:0]   w_addend;
    logic [c_ACC_W-1:0]   w_sum;
    logic [c_ACC_W-1:0]   w_acc_nxt;
    logic [c_EXT_W-1:0]   w_q_nxt;
    logic                 w_qm1_nxt;

    function automatic logic [c_EXT_W-1:0] f_extend(input logic [WIDTH-1:0] x,
                                                    input logic s);
        return s ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    endfunction

    booth_recoder #(
        .WIN_W (c_WIN_W)
    ) u_recoder (
        .window (w_window),
        .neg    (w_neg),
        .one    (w_one),
        .two    (w_two)
    );

    // Operands only span WIDTH+1 signed bits, so +/-2A never leaves c_ACC_W bits
    assign w_mag    = w_two ? {r_mcand, 1'b0} :
                      w_one ? {r_mcand[c_EXT_W-1], r_mcand} : '0;
    assign w_addend = w_neg ? (~w_mag + c_ACC_W'(1)) : w_mag;
    assign w_sum    = r_acc + w_addend;

    generate
        if (c_RADIX4) begin : g_shift_r4
            assign w_window  = {r_q[1:0], r_qm1};
            assign w_acc_nxt = {{2{w_sum[c_ACC_W-1]}}, w_sum[c_ACC_W-1:2]};
            assign w_q_nxt   = {w_sum[1:0], r_q[c_EXT_W-1:2]};
            assign w_qm1_nxt = r_q[1];
        end else begin : g_shift_r2
            assign w_window  = {r_q[0], r_qm1};
            assign w_acc_nxt = {w_sum[c_ACC_W-1], w_sum[c_ACC_W-1:1]};
            assign w_q_nxt   = {w_sum[0], r_q[c_EXT_W-1:1]};
            assign w_qm1_nxt = r_q[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_qm1       <= 1'b0;
            r_mcand     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= f_extend(multiplicand, tc);
                        r_q        <= f_extend(multiplier, tc);
                        r_acc      <= '0;
                        r_qm1      <= 1'b0;
                        r_cnt      <= c_N_ITER;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= w_qm1_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_product   <= {w_acc_nxt[2*WIDTH-c_EXT_W-1:0], w_q_nxt};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_booth_mult_seq                                            |
// | Description : Self-checking bench for booth_mult_seq against an integer    |
// |               product model; honours BOOTH_RADIX4_EN for latency.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_booth_mult_seq #(
    parameter int WIDTH = 8
);

`ifdef BOOTH_RADIX4_EN
    localparam int c_LAT = (WIDTH + 2) / 2;
`else
    localparam int c_LAT = WIDTH + 2;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               tc = 1'b0;
    logic [WIDTH-1:0]   multiplicand = '0;
    logic [WIDTH-1:0]   multiplier = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2*WIDTH-1:0] product;

    int n_checks = 0;
    int n_errors = 0;

    booth_mult_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tc           (tc),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic t);
        longint sa, sb, p;
        sa = t ? longint'($signed(a)) : longint'({1'b0, a});
        sb = t ? longint'($signed(b)) : longint'({1'b0, b});
        p  = sa * sb;
        return p[2*WIDTH-1:0];
    endfunction

    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic t);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        multiplicand = a;
        multiplier   = b;
        tc           = t;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        multiplicand = WIDTH'($urandom);
        multiplier   = WIDTH'($urandom);
        tc           = 1'($urandom);
    endtask

    // Waits for the result, holds it for `hold` cycles while poking in_valid, then drains
    task automatic finish_op(input string tag, input logic [2*WIDTH-1:0] exp, input int hold);
        int cyc;
        bit stable;
        cyc = 0;
        while (!out_valid && cyc < 4 * c_LAT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(c_LAT));
        check({tag, "_product"}, product, exp);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid     = 1'b1;
            multiplicand = WIDTH'($urandom);
            multiplier   = WIDTH'($urandom);
            @(posedge clk);
            #1;
            if (product !== exp || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0)
            check({tag, "_held_stable"}, 64'(stable), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic t, input logic [2*WIDTH-1:0] exp, input int hold);
        accept(a, b, t);
        finish_op(tag, exp, hold);
    endtask

    initial begin
        logic [WIDTH-1:0]   mn;
        logic [WIDTH-1:0]   ones;
        logic [2*WIDTH-1:0] exp;
        bit                 quiet;

        mn   = '0;
        mn[WIDTH-1] = 1'b1;
        ones = '1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_product", product, 0);
        rst = 1'b0;

        run_op("s_12x10", WIDTH'(12), WIDTH'(10), 1'b1, (2*WIDTH)'(120), 0);
        exp = '0 - (2*WIDTH)'(120);
        run_op("s_m12x10", '0 - WIDTH'(12), WIDTH'(10), 1'b1, exp, 0);
        exp = '0;
        exp[2*WIDTH-2] = 1'b1;
        run_op("s_minxmin", mn, mn, 1'b1, exp, 0);
        exp = (2*WIDTH)'(ones) * (2*WIDTH)'(ones);
        run_op("u_onesxones", ones, ones, 1'b0, exp, 0);
        exp = (2*WIDTH)'(mn) << 1;
        run_op("u_minx2", mn, WIDTH'(2), 1'b0, exp, 0);
        run_op("zero_operand", '0, WIDTH'($urandom), 1'b1, '0, 0);

        // Backpressure with ignored in_valid, then a fresh accept
        run_op("backpressure", WIDTH'(7), WIDTH'(9), 1'b0, (2*WIDTH)'(63), 7);
        run_op("after_bp", WIDTH'(3), '0 - WIDTH'(5), 1'b1, '0 - (2*WIDTH)'(15), 0);

        // Reset mid-CALC aborts without a result pulse
        accept(WIDTH'(11), WIDTH'(13), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_product", product, 0);
        check("abort_in_ready", in_ready, 1);
        quiet = 1'b1;
        for (int i = 0; i < c_LAT + 2; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        check("abort_no_pulse", 64'(quiet), 1);
        run_op("after_abort", WIDTH'(11), WIDTH'(13), 1'b0, (2*WIDTH)'(143), 0);

        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] a, b;
            logic             t;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            t = 1'($urandom);
            if ($urandom_range(0, 15) == 0) a = '0;
            if ($urandom_range(0, 15) == 0) b = mn;
            run_op("rand", a, b, t, ref_prod(a, b, t), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised, multi-cycle, sequential Booth multiplier; the successor to the fixed 8-bit radix-2 unit.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Supports signed or unsigned operands per transaction.
- Returns the full 2*WIDTH-bit product with output valid/ready backpressure.
- Sits in the datapath between operand registers and the accumulate/writeback stage.

Parameters:
- WIDTH, 8: operand width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH+3): width of the internal iteration counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- tc  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  A*B, held stable while out_valid=1.

Behaviour:
- Reset values (clk: rst=1): state=IDLE, in_ready=1, out_valid=0, product=0, internal accumulator/counter=0. Reset mid-CALC or mid-DONE aborts the operation; no out_valid pulse is produced.
- Operand extension: E = WIDTH+2. Both operands are extended to E bits: sign-extended if tc=1, zero-extended if tc=0. The product is the low 2*WIDTH bits of the E x E signed product, which is exact in both modes.
- Accept: an edge with in_valid & in_ready loads the extended operands, clears the accumulator, clears q(-1), loads the counter with N and moves to CALC. tc is latched at this edge.
- Iteration count: N = E in radix-2 (10 for WIDTH=8); N = E/2 in radix-4 (5 for WIDTH=8).
- CALC: each cycle decodes the Booth window and adds 0, +A or -A (radix-2), or 0, +/-A, +/-2A (radix-4) into the upper half of the shift register. The shift register then arithmetic-shifts right by 1 (radix-2) or 2 (radix-4), and the counter decrements.
- CALC to DONE: on the edge where counter==1, product is registered and out_valid=1 after that edge.
- Latency: out_valid is high exactly N cycles after the accept edge.
- Arithmetic width: adder width E+1 bits, so -2A with A = most-negative cannot overflow.
- DONE: product and out_valid are held until out_ready=1. On that edge: out_valid to 0, state to IDLE, in_ready to 1 after the edge. There is no same-cycle accept/output overlap (in_ready=0 in DONE).
- in_valid while busy is ignored; the operands are not captured.
- Input changes after the accept edge have no effect on the result.
- Boundaries:
  - tc=1, A=B=most-negative gives +2^(2*WIDTH-2).
  - tc=0, all-ones*all-ones gives (2^WIDTH-1)^2.
  - Any zero operand gives 0 with the same latency (no early termination).

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined: radix-4 modified Booth recoding over 3-bit windows, N = E/2, two bits shifted per cycle.
- Undefined: radix-2 Booth over 2-bit windows, N = E, one bit shifted per cycle.
- Port list, handshake and results are identical in both builds; only latency differs.

Decomposition:
- booth_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - Booth digit encoding constants (ZERO, POS1, NEG1, POS2, NEG2);
  - function n_iter(WIDTH, radix4).
- Sub-module booth_recoder (combinational): takes the 3-bit window (2-bit in radix-2) and outputs {neg, one, two}. It is instantiated once by booth_mult_seq.

Test Plan:
- Radix-2 build, WIDTH=8, tc=1, A=12, B=10 -> product=120; out_valid exactly 10 cycles after accept.
- tc=1, A=-12 (0xF4), B=10 -> product=0xFF88 (-120). tc=1, A=B=0x80 -> product=0x4000 (16384).
- tc=0, A=B=0xFF -> product=0xFE01 (65025). tc=0, A=0x80, B=0x02 -> product=0x0100.
- Backpressure: hold out_ready=0 for 7 cycles -> product and out_valid stable, in_ready=0; a new in_valid during this time is ignored. Release -> IDLE, then the next accept succeeds.
- Assert rst 3 cycles into CALC -> next cycle out_valid=0, product=0, in_ready=1; the following operation gives a correct result.
- BOOTH_RADIX4_EN build, WIDTH=8 and WIDTH=16: random 10k signed/unsigned pairs versus a reference model -> all match; latency 5 and 9 cycles respectively.
